instr_prefetch: RTL and testbench

Instruction prefetch unit between program ROM and the sequencer. It fetches 16-bit instruction words from sequential ROM addresses ahead of use and holds them in a small FIFO with their addresses. It presents them to the sequencer through a valid/ready handshake. A redirect input flushes the FIFO and restarts fetch at a new PC when a branch is taken.

---
 rtl/instr_prefetch.sv | 150 +++++++++++++++
 tb/tb_instr_prefetch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// ---------------------------------------------------------------------------
// instr_prefetch
//
// Fetches instruction words from sequential ROM addresses ahead of use and
// queues them, with the address each came from, in a small FIFO. The
// sequencer takes them through a valid/ready handshake. A redirect flushes
// the FIFO and restarts fetching at a new PC.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   rom_req      ROM read request (registered)
//   rom_addr     ROM read address (registered), stable while rom_req=1
//   rom_ack      ROM read complete, rom_data valid this cycle
//   rom_data     ROM read data
//   ir_valid     FIFO head holds an instruction
//   ir_data      head instruction word (0 when ir_valid=0)
//   ir_pc        address of the head word (0 when ir_valid=0)
//   ir_ready     sequencer consumes the head this cycle
//   redirect     taken branch: flush and refetch from redirect_pc
//   redirect_pc  new fetch address, sampled when redirect=1
// ---------------------------------------------------------------------------
module instr_prefetch #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [DATA_W-1:0] mem_word [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              pop;
    logic              push;

    assign ir_valid = (count != '0);
    assign ir_data  = ir_valid ? mem_word[rd_ptr] : '0;
    assign ir_pc    = ir_valid ? mem_pc[rd_ptr]   : '0;

    assign pop  = ir_valid & ir_ready;
    // Only an ack in REQ carries live data; a redirect in the same cycle
    // flushes the pointers, so the stale write below is never seen.
    assign push = (state == REQ) & rom_ack;

    always_comb begin
        count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    // FIFO storage carries data only, no reset needed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_word[wr_ptr] <= rom_data;
            mem_pc[wr_ptr]   <= rom_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            rom_req  <= 1'b0;
            rom_addr <= '0;
        end else if (redirect) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= redirect_pc;
            if (state != IDLE && !rom_ack) begin
                // A request is still outstanding: keep it on the old address
                // and throw its data away when it completes.
                state   <= DISCARD;
                rom_req <= 1'b1;
            end else begin
                state    <= REQ;
                rom_req  <= 1'b1;
                rom_addr <= redirect_pc;
            end
        end else begin
            count <= count_next;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (count_next < DEPTH_C) begin
                        state    <= REQ;
                        rom_req  <= 1'b1;
                        rom_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (rom_ack) begin
                        fetch_pc <= fetch_pc + ADDR_W'(1);
                        // A pop alongside the filling ack keeps a slot free.
                        if (count_next < DEPTH_C) begin
                            rom_addr <= fetch_pc + ADDR_W'(1);
                        end else begin
                            state   <= IDLE;
                            rom_req <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (rom_ack) begin
                        state    <= REQ;
                        rom_addr <= fetch_pc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rom_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch
//
// Bench for instr_prefetch. The bench plays the ROM (configurable ack
// latency) and the sequencer. A transaction-level reference model keeps the
// expected FIFO contents as a queue of {word, pc} and the next expected fetch
// address; it is updated from acks, pops, redirects and resets. A second
// instance with RESET_PC=0xFE and a self-acking ROM checks address wrap.
// ---------------------------------------------------------------------------
module tb_instr_prefetch;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [DATA_W-1:0] rom_data;
    logic              ir_valid;
    logic [DATA_W-1:0] ir_data;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    logic              rom_req2;
    logic [ADDR_W-1:0] rom_addr2;
    logic [DATA_W-1:0] rom_data2;
    logic              ir_valid2;
    logic [DATA_W-1:0] ir_data2;
    logic [ADDR_W-1:0] ir_pc2;

    always #5 clock = ~clock;

    assign rom_data2 = {8'hA5, rom_addr2};

    instr_prefetch #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(8'h00)
    ) dut (
        .clock(clock), .reset(reset),
        .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ack(rom_ack), .rom_data(rom_data),
        .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc),
        .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instr_prefetch #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(8'hFE)
    ) dut_fe (
        .clock(clock), .reset(reset),
        .rom_req(rom_req2), .rom_addr(rom_addr2),
        .rom_ack(rom_req2), .rom_data(rom_data2),
        .ir_valid(ir_valid2), .ir_data(ir_data2), .ir_pc(ir_pc2),
        .ir_ready(1'b1),
        .redirect(1'b0), .redirect_pc(8'h00)
    );

    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            q[$];
    logic [DATA_W-1:0] rom [256];
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] acked[$];
    logic [ADDR_W-1:0] popped[$];
    bit                discard;
    bit                armed;
    bit                rand_lat;
    int                lat;
    int                wcnt;
    int                live_acks;
    int                total;
    int                bad;
    bit                prev_req;
    bit                prev_ack;
    bit                prev_reset;
    logic [ADDR_W-1:0] prev_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: check outputs against the model, play the ROM, advance the
    // model by what the coming edge will do. Enters and leaves at negedge.
    task automatic cycle();
        bit                ack;
        bit                req_s;
        bit                pop;
        logic [ADDR_W-1:0] addr_s;
        entry_t            e;
        req_s  = (rom_req === 1'b1);
        addr_s = rom_addr;
        if (armed) begin
            e = (q.size() != 0) ? q[0] : '0;
            chk("ir_valid", 32'(ir_valid), 32'(q.size() != 0));
            chk("ir_data", 32'(ir_data), 32'(e.word));
            chk("ir_pc", 32'(ir_pc), 32'(e.pc));
            if (q.size() == DEPTH) chk("full_no_req", 32'(rom_req), 32'(0));
            if (req_s && !discard) chk("rom_addr_seq", 32'(rom_addr), 32'(exp_pc));
            if (req_s && prev_req && !prev_ack && !prev_reset)
                chk("rom_addr_hold", 32'(rom_addr), 32'(prev_addr));
        end
        ack      = req_s && (wcnt >= lat);
        rom_ack  = ack;
        rom_data = ack ? rom[addr_s] : 16'($urandom);
        pop      = (q.size() != 0) && ir_ready;
        if (reset) begin
            q.delete();
            exp_pc  = 8'h00;
            discard = 1'b0;
        end else if (redirect) begin
            q.delete();
            discard = req_s && !ack;
            exp_pc  = redirect_pc;
        end else begin
            if (pop) begin
                popped.push_back(q[0].pc);
                void'(q.pop_front());
            end
            if (ack) begin
                if (discard) begin
                    discard = 1'b0;
                end else begin
                    acked.push_back(addr_s);
                    q.push_back({rom[addr_s], addr_s});
                    exp_pc = exp_pc + 8'd1;
                    live_acks++;
                end
            end
        end
        prev_req   = req_s;
        prev_ack   = ack;
        prev_reset = reset;
        prev_addr  = addr_s;
        @(posedge clock);
        if (reset) armed = 1'b1;
        if (reset || !req_s || ack) begin
            wcnt = 0;
            if (ack && rand_lat) lat = $urandom_range(0, 3);
        end else begin
            wcnt++;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [ADDR_W-1:0] p;
        bit                found;
        total = 0; bad = 0; armed = 0; discard = 0; rand_lat = 0;
        lat = 0; wcnt = 0; live_acks = 0; exp_pc = '0;
        prev_req = 0; prev_ack = 0; prev_reset = 1; prev_addr = '0;
        reset = 1'b1; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rom_ack = 1'b0; rom_data = '0;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        @(negedge clock);

        // Reset state, then zero-wait streaming with ir_ready high.
        ir_ready = 1'b1;
        do_reset();
        chk("rst_rom_req", 32'(rom_req), 32'(0));
        chk("rst_rom_addr", 32'(rom_addr), 32'(0));
        chk("rst_ir_valid", 32'(ir_valid), 32'(0));
        chk("rst_ir_data", 32'(ir_data), 32'(0));
        chk("rst_ir_pc", 32'(ir_pc), 32'(0));
        cycle();
        chk("first_req", 32'(rom_req), 32'(1));
        chk("first_addr", 32'(rom_addr), 32'(0));
        chk("fe_first_addr", 32'(rom_addr2), 32'(8'hFE));
        for (int i = 1; i <= 5; i++) begin
            cycle();
            p = 8'hFE + 8'(i - 1);
            chk("stream_addr", 32'(rom_addr), 32'(i));
            chk("stream_pc", 32'(ir_pc), 32'(i - 1));
            chk("stream_data", 32'(ir_data), 32'(rom[8'(i - 1)]));
            if (i <= 4) begin
                chk("fe_wrap_pc", 32'(ir_pc2), 32'(p));
                chk("fe_wrap_data", 32'(ir_data2), 32'({8'hA5, p}));
            end
        end

        // Stalled sequencer: exactly DEPTH fetches, then drain in order.
        ir_ready = 1'b0;
        do_reset();
        acked.delete();
        popped.delete();
        for (int i = 0; i < 12; i++) cycle();
        chk("full_acks", 32'(acked.size()), 32'(4));
        chk("full_idle", 32'(rom_req), 32'(0));
        chk("full_head", 32'(ir_pc), 32'(0));
        ir_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("drain_cnt", 32'(popped.size() >= 4), 32'(1));
        if (popped.size() >= 4)
            for (int i = 0; i < 4; i++) chk("drain_order", 32'(popped[i]), 32'(i));
        chk("resume_cnt", 32'(acked.size() > 4), 32'(1));
        if (acked.size() > 4) chk("resume_addr", 32'(acked[4]), 32'(4));

        // Slow ROM, redirect to 0x40 in the second wait cycle.
        ir_ready = 1'b1;
        lat = 3;
        do_reset();
        cycle();
        cycle();
        redirect = 1'b1;
        redirect_pc = 8'h40;
        cycle();
        redirect = 1'b0;
        chk("disc_req", 32'(rom_req), 32'(1));
        chk("disc_addr", 32'(rom_addr), 32'(0));
        chk("disc_valid", 32'(ir_valid), 32'(0));
        cycle();
        chk("disc_hold", 32'(rom_addr), 32'(0));
        cycle();
        chk("redir_req", 32'(rom_req), 32'(1));
        chk("redir_addr", 32'(rom_addr), 32'(8'h40));
        chk("redir_valid", 32'(ir_valid), 32'(0));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (ir_valid === 1'b1) found = 1'b1;
        end
        chk("redir_found", 32'(found), 32'(1));
        chk("redir_pc", 32'(ir_pc), 32'(8'h40));
        chk("redir_word", 32'(ir_data), 32'(rom[8'h40]));

        // Redirect coinciding with an ack and a pop.
        lat = 0;
        ir_ready = 1'b0;
        do_reset();
        cycle();
        cycle();
        cycle();
        chk("pre_flush_pc", 32'(ir_pc), 32'(0));
        ir_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'h80;
        cycle();
        redirect = 1'b0;
        chk("flush_valid", 32'(ir_valid), 32'(0));
        chk("flush_req", 32'(rom_req), 32'(1));
        chk("flush_addr", 32'(rom_addr), 32'(8'h80));
        cycle();
        chk("flush_next_valid", 32'(ir_valid), 32'(1));
        chk("flush_next_pc", 32'(ir_pc), 32'(8'h80));

        // Reset while requesting with two entries queued.
        ir_ready = 1'b0;
        do_reset();
        cycle();
        cycle();
        cycle();
        chk("mid_queued", 32'(ir_valid), 32'(1));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_req", 32'(rom_req), 32'(0));
        chk("mid_rst_valid", 32'(ir_valid), 32'(0));
        cycle();
        chk("mid_restart_req", 32'(rom_req), 32'(1));
        chk("mid_restart_addr", 32'(rom_addr), 32'(0));

        // Random traffic against the model.
        rand_lat = 1'b1;
        lat = $urandom_range(0, 3);
        live_acks = 0;
        for (int i = 0; i < 4000; i++) begin
            ir_ready    = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 99) < 3);
            redirect_pc = 8'($urandom);
            reset       = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;
        redirect = 1'b0;
        chk("rand_progress", 32'(live_acks > 800), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
